// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares the single-ported main-memory line interface between the icache and
//   the dcache. Round-robin grant, one outstanding memory transaction at a time.
//   The winning request is latched and held toward memory until mem_ack_i; the
//   ack and read line are then steered back to the owner in the same cycle.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   icache_req_i/addr/wen/wdata  icache line request (held until icache_ack_o)
//   icache_rdata_o, icache_ack_o read line and one-cycle completion to icache
//   dcache_req_i/addr/wen/wdata  dcache line request (held until dcache_ack_o)
//   dcache_rdata_o, dcache_ack_o read line and one-cycle completion to dcache
//   mem_req_o/addr/wen/wdata     latched request toward main memory
//   mem_rdata_i, mem_ack_i       memory read line and one-cycle completion
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  icache_req_i,
    input  logic [ADDR_WIDTH-1:0] icache_addr_i,
    input  logic                  icache_wen_i,
    input  logic [LINE_WIDTH-1:0] icache_wdata_i,
    output logic [LINE_WIDTH-1:0] icache_rdata_o,
    output logic                  icache_ack_o,

    input  logic                  dcache_req_i,
    input  logic [ADDR_WIDTH-1:0] dcache_addr_i,
    input  logic                  dcache_wen_i,
    input  logic [LINE_WIDTH-1:0] dcache_wdata_i,
    output logic [LINE_WIDTH-1:0] dcache_rdata_o,
    output logic                  dcache_ack_o,

    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_wen_o,
    output logic [LINE_WIDTH-1:0] mem_wdata_o,
    input  logic [LINE_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ack_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_e;

    typedef enum logic {
        MST_I = 1'b0,
        MST_D = 1'b1
    } master_e;

    // Memory command payload as latched toward main memory
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  wen;
        logic [LINE_WIDTH-1:0] wdata;
    } line_cmd_t;

    state_e                  state_q, state_d;
    master_e                 last_grant_q, last_grant_d;
    logic                    mem_req_q, mem_req_d;
    line_cmd_t               mem_cmd_q, mem_cmd_d;
    logic [LINE_WIDTH-1:0]   icache_rdata_q, icache_rdata_d;
    logic [LINE_WIDTH-1:0]   dcache_rdata_q, dcache_rdata_d;

    line_cmd_t               icache_cmd_c;
    line_cmd_t               dcache_cmd_c;
    logic                    grant_i_c;
    logic                    grant_d_c;
    logic                    ack_i_c;
    logic                    ack_d_c;

    // Pack requester inputs into command payloads
    always_comb begin
        icache_cmd_c       = '0;
        icache_cmd_c.addr  = icache_addr_i;
        icache_cmd_c.wen   = icache_wen_i;
        icache_cmd_c.wdata = icache_wdata_i;
        dcache_cmd_c       = '0;
        dcache_cmd_c.addr  = dcache_addr_i;
        dcache_cmd_c.wen   = dcache_wen_i;
        dcache_cmd_c.wdata = dcache_wdata_i;
    end

    // Round-robin pick: on a tie the master that did not win last time goes
    always_comb begin
        grant_i_c = 1'b0;
        grant_d_c = 1'b0;
        if (icache_req_i && dcache_req_i) begin
            if (last_grant_q == MST_D) begin
                grant_i_c = 1'b1;
            end else begin
                grant_d_c = 1'b1;
            end
        end else begin
            grant_i_c = icache_req_i;
            grant_d_c = dcache_req_i;
        end
    end

    // Memory completion only counts while a grant is outstanding
    always_comb begin
        ack_i_c = 1'b0;
        ack_d_c = 1'b0;
        if (state_q == GNT_I) begin
            ack_i_c = mem_ack_i;
        end
        if (state_q == GNT_D) begin
            ack_d_c = mem_ack_i;
        end
    end

    // Next-state and latched-field logic
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        mem_req_d      = mem_req_q;
        mem_cmd_d      = mem_cmd_q;
        icache_rdata_d = icache_rdata_q;
        dcache_rdata_d = dcache_rdata_q;

        unique case (state_q)
            IDLE: begin
                mem_req_d = 1'b0;
                if (grant_i_c) begin
                    state_d      = GNT_I;
                    last_grant_d = MST_I;
                    mem_req_d    = 1'b1;
                    mem_cmd_d    = icache_cmd_c;
                end else if (grant_d_c) begin
                    state_d      = GNT_D;
                    last_grant_d = MST_D;
                    mem_req_d    = 1'b1;
                    mem_cmd_d    = dcache_cmd_c;
                end
            end
            GNT_I: begin
                // Requester inputs are deliberately ignored until memory acks
                if (mem_ack_i) begin
                    state_d        = IDLE;
                    mem_req_d      = 1'b0;
                    icache_rdata_d = mem_rdata_i;
                end
            end
            GNT_D: begin
                if (mem_ack_i) begin
                    state_d        = IDLE;
                    mem_req_d      = 1'b0;
                    dcache_rdata_d = mem_rdata_i;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            last_grant_q   <= MST_D;
            mem_req_q      <= 1'b0;
            mem_cmd_q      <= '0;
            icache_rdata_q <= '0;
            dcache_rdata_q <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            mem_req_q      <= mem_req_d;
            mem_cmd_q      <= mem_cmd_d;
            icache_rdata_q <= icache_rdata_d;
            dcache_rdata_q <= dcache_rdata_d;
        end
    end

    // Memory side is purely registered
    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = mem_cmd_q.addr;
    assign mem_wen_o   = mem_cmd_q.wen;
    assign mem_wdata_o = mem_cmd_q.wdata;

    // Ack and read line reach the owner in the memory ack cycle; otherwise the
    // last delivered line is held
    assign icache_ack_o   = ack_i_c;
    assign dcache_ack_o   = ack_d_c;
    assign icache_rdata_o = ack_i_c ? mem_rdata_i : icache_rdata_q;
    assign dcache_rdata_o = ack_d_c ? mem_rdata_i : dcache_rdata_q;

endmodule
